// File: rtl/trap_controller.sv
// trap_controller: machine-mode trap sequencer between pipeline and CSR file.
// Arbitrates synchronous exceptions, MRET and MEI/MSI/MTI interrupts, drains
// the pipeline for interrupts, pulses CSR strobes and issues one redirect.
// Optional feature macro: TRAP_VECTORED_EN -- vectored interrupt targets
// (base + code*4) when csr_mtvec[1:0] == 2'b01; exceptions always use base.
// CSR strobes are registered from the stall_n value seen on the preceding
// edge, so an exception accepted in cycle N strobes in N+1 and redirects in N+2.

module trap_controller #(
  parameter int unsigned DRAIN_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_n,
  input  logic        exc_req,
  input  logic [3:0]  exc_cause,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic        mret_req,
  output logic        pipe_hold,
  input  logic        pipe_drained,
  input  logic [31:0] int_pc,
  input  logic [31:0] csr_mstatus,
  input  logic [31:0] csr_mie,
  input  logic [31:0] csr_mip,
  input  logic [31:0] csr_mtvec,
  input  logic [31:0] csr_mepc,
  output logic        exception_occurred,
  output logic        exception_returned,
  output logic [31:0] new_mepc,
  output logic [31:0] new_mcause,
  output logic [31:0] new_mtval,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        trap_busy
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned CW   = $clog2(DRAIN_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_COMMIT,
    ST_RET,
    ST_REDIRECT
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0]        code_q, code_d;
  logic [XLEN-1:0]   lat_pc_q, lat_pc_d;
  logic [XLEN-1:0]   lat_cause_q, lat_cause_d;
  logic [XLEN-1:0]   lat_tval_q, lat_tval_d;
  logic              exc_occ_q, exc_occ_d;
  logic              exc_ret_q, exc_ret_d;
  logic [XLEN-1:0]   new_mepc_q, new_mepc_d;
  logic [XLEN-1:0]   new_mcause_q, new_mcause_d;
  logic [XLEN-1:0]   new_mtval_q, new_mtval_d;
  logic              redir_valid_q, redir_valid_d;
  logic [XLEN-1:0]   redir_pc_q, redir_pc_d;
  logic              pipe_hold_q, pipe_hold_d;
  logic              busy_q, busy_d;

  logic              mei_c, msi_c, mti_c;
  logic              int_pend_c;
  logic [3:0]        int_code_c;
  logic [XLEN-1:0]   trap_target_c;
  logic              unused_c;

  // Enabled-and-pending interrupt detection, globally gated by MIE.
  assign mei_c      = csr_mie[11] & csr_mip[11];
  assign msi_c      = csr_mie[3]  & csr_mip[3];
  assign mti_c      = csr_mie[7]  & csr_mip[7];
  assign int_pend_c = csr_mstatus[3] & (mei_c | msi_c | mti_c);

  // CSR bits this block does not consume.
  assign unused_c = ^{csr_mstatus[31:4], csr_mstatus[2:0],
                      csr_mie[31:12], csr_mie[10:8], csr_mie[6:4], csr_mie[2:0],
                      csr_mip[31:12], csr_mip[10:8], csr_mip[6:4], csr_mip[2:0],
                      csr_mtvec[1:0]};

  // Fixed interrupt priority: MEI > MSI > MTI.
  always_comb begin
    int_code_c = 4'd7;
    if (mei_c) begin
      int_code_c = 4'd11;
    end else if (msi_c) begin
      int_code_c = 4'd3;
    end
  end

  // Trap target from mtvec; vectoring applies to interrupts only (mcause[31]).
  always_comb begin
    trap_target_c = {csr_mtvec[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
    if (lat_cause_q[31] && (csr_mtvec[1:0] == 2'b01)) begin
      trap_target_c = {csr_mtvec[31:2], 2'b00} + {26'b0, lat_cause_q[3:0], 2'b00};
    end
`else
    trap_target_c = {csr_mtvec[31:2], 2'b00};
`endif
  end

  // Next-state and registered-output logic for the trap sequencer.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    code_d        = code_q;
    lat_pc_d      = lat_pc_q;
    lat_cause_d   = lat_cause_q;
    lat_tval_d    = lat_tval_q;
    exc_occ_d     = 1'b0;
    exc_ret_d     = 1'b0;
    new_mepc_d    = new_mepc_q;
    new_mcause_d  = new_mcause_q;
    new_mtval_d   = new_mtval_q;
    redir_valid_d = redir_valid_q;
    redir_pc_d    = redir_pc_q;
    pipe_hold_d   = pipe_hold_q;

    unique case (state_q)
      ST_IDLE: begin
        if (exc_req && stall_n) begin
          state_d     = ST_COMMIT;
          lat_pc_d    = exc_pc;
          lat_cause_d = {28'b0, exc_cause};
          lat_tval_d  = exc_tval;
          exc_occ_d   = 1'b1;
        end else if (mret_req && stall_n) begin
          state_d   = ST_RET;
          exc_ret_d = 1'b1;
        end else if (int_pend_c) begin
          state_d     = ST_DRAIN;
          cnt_d       = '0;
          code_d      = int_code_c;
          pipe_hold_d = 1'b1;
        end
      end

      ST_DRAIN: begin
        cnt_d = cnt_q + CW'(1);
        if (exc_req && stall_n) begin
          state_d     = ST_COMMIT;
          lat_pc_d    = exc_pc;
          lat_cause_d = {28'b0, exc_cause};
          lat_tval_d  = exc_tval;
          exc_occ_d   = 1'b1;
        end else if (!int_pend_c) begin
          state_d     = ST_IDLE;
          pipe_hold_d = 1'b0;
        end else if (pipe_drained) begin
          state_d     = ST_COMMIT;
          lat_pc_d    = int_pc;
          lat_cause_d = {1'b1, 27'b0, code_q};
          lat_tval_d  = '0;
          exc_occ_d   = stall_n;
        end else if (cnt_q == CW'(DRAIN_MAX - 1)) begin
          state_d     = ST_IDLE;
          pipe_hold_d = 1'b0;
        end
      end

      ST_COMMIT: begin
        if (exc_occ_q) begin
          state_d       = ST_REDIRECT;
          redir_valid_d = 1'b1;
          redir_pc_d    = trap_target_c;
        end else if (stall_n) begin
          exc_occ_d = 1'b1;
        end
      end

      ST_RET: begin
        if (exc_ret_q) begin
          state_d       = ST_REDIRECT;
          redir_valid_d = 1'b1;
          redir_pc_d    = csr_mepc;
        end else if (stall_n) begin
          exc_ret_d = 1'b1;
        end
      end

      ST_REDIRECT: begin
        if (redirect_ready) begin
          state_d       = ST_IDLE;
          redir_valid_d = 1'b0;
          pipe_hold_d   = 1'b0;
        end
      end

      default: begin
        state_d       = ST_IDLE;
        redir_valid_d = 1'b0;
        pipe_hold_d   = 1'b0;
      end
    endcase

    // Trap payload is published only alongside the entry strobe.
    if (exc_occ_d) begin
      new_mepc_d   = lat_pc_d;
      new_mcause_d = lat_cause_d;
      new_mtval_d  = lat_tval_d;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      code_q        <= '0;
      lat_pc_q      <= '0;
      lat_cause_q   <= '0;
      lat_tval_q    <= '0;
      exc_occ_q     <= 1'b0;
      exc_ret_q     <= 1'b0;
      new_mepc_q    <= '0;
      new_mcause_q  <= '0;
      new_mtval_q   <= '0;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      pipe_hold_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      code_q        <= code_d;
      lat_pc_q      <= lat_pc_d;
      lat_cause_q   <= lat_cause_d;
      lat_tval_q    <= lat_tval_d;
      exc_occ_q     <= exc_occ_d;
      exc_ret_q     <= exc_ret_d;
      new_mepc_q    <= new_mepc_d;
      new_mcause_q  <= new_mcause_d;
      new_mtval_q   <= new_mtval_d;
      redir_valid_q <= redir_valid_d;
      redir_pc_q    <= redir_pc_d;
      pipe_hold_q   <= pipe_hold_d;
      busy_q        <= busy_d;
    end
  end

  assign pipe_hold          = pipe_hold_q;
  assign exception_occurred = exc_occ_q;
  assign exception_returned = exc_ret_q;
  assign new_mepc           = new_mepc_q;
  assign new_mcause         = new_mcause_q;
  assign new_mtval          = new_mtval_q;
  assign redirect_valid     = redir_valid_q;
  assign redirect_pc        = redir_pc_q;
  assign trap_busy          = busy_q;

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: directed scenarios with randomized
// payloads, expected values from a small priority/target reference model.

module tb_trap_controller;

  localparam int unsigned DRAIN_MAX = 16;
`ifdef TRAP_VECTORED_EN
  localparam bit VEC_EN = 1'b1;
`else
  localparam bit VEC_EN = 1'b0;
`endif

  logic        clk, rst, stall_n, exc_req, mret_req, pipe_hold, pipe_drained;
  logic [3:0]  exc_cause;
  logic [31:0] exc_pc, exc_tval, int_pc;
  logic [31:0] csr_mstatus, csr_mie, csr_mip, csr_mtvec, csr_mepc;
  logic        exception_occurred, exception_returned, redirect_valid;
  logic        redirect_ready, trap_busy;
  logic [31:0] new_mepc, new_mcause, new_mtval, redirect_pc;

  int checks = 0;
  int errors = 0;

  trap_controller #(.DRAIN_MAX(DRAIN_MAX)) dut (
    .clk(clk), .rst(rst), .stall_n(stall_n), .exc_req(exc_req),
    .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .mret_req(mret_req), .pipe_hold(pipe_hold), .pipe_drained(pipe_drained),
    .int_pc(int_pc), .csr_mstatus(csr_mstatus), .csr_mie(csr_mie),
    .csr_mip(csr_mip), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
    .exception_occurred(exception_occurred),
    .exception_returned(exception_returned),
    .new_mepc(new_mepc), .new_mcause(new_mcause), .new_mtval(new_mtval),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .trap_busy(trap_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: highest-priority enabled+pending interrupt, -1 if none.
  function automatic int exp_code(input logic [31:0] mie, input logic [31:0] mip);
    int prio[3] = '{11, 3, 7};
    foreach (prio[k]) begin
      if (mie[prio[k]] && mip[prio[k]]) return prio[k];
    end
    return -1;
  endfunction

  // Reference model: trap target address.
  function automatic logic [31:0] exp_target(input logic [31:0] mtvec, input bit is_int,
                                             input int code);
    logic [31:0] base;
    base = mtvec & 32'hFFFF_FFFC;
    if (VEC_EN && is_int && (mtvec[1:0] == 2'b01)) return base + 32'(code * 4);
    return base;
  endfunction

  // Entered in the first REDIRECT cycle; holds, then accepts.
  task automatic do_redirect(input string tag, input logic [31:0] exp_pc, input int hold);
    check({tag, "_rv"}, 32'(redirect_valid), 32'd1);
    check({tag, "_rpc"}, redirect_pc, exp_pc);
    for (int h = 0; h < hold; h++) begin
      step();
      check({tag, "_rv_hold"}, 32'(redirect_valid), 32'd1);
      check({tag, "_rpc_hold"}, redirect_pc, exp_pc);
    end
    redirect_ready = 1'b1;
    step();
    redirect_ready = 1'b0;
    check({tag, "_rv_done"}, 32'(redirect_valid), 32'd0);
    check({tag, "_busy_done"}, 32'(trap_busy), 32'd0);
    check({tag, "_hold_done"}, 32'(pipe_hold), 32'd0);
  endtask

  // Exception with randomizable stall before acceptance.
  task automatic run_exc(input string tag, input logic [3:0] cause, input logic [31:0] pc,
                         input logic [31:0] tval, input int stall_cycles, input int hold);
    exc_req = 1'b1; exc_cause = cause; exc_pc = pc; exc_tval = tval;
    stall_n = 1'b0;
    for (int s = 0; s < stall_cycles; s++) begin
      step();
      check({tag, "_stalled_busy"}, 32'(trap_busy), 32'd0);
      check({tag, "_stalled_occ"}, 32'(exception_occurred), 32'd0);
    end
    stall_n = 1'b1;
    step();
    exc_req = 1'b0; mret_req = 1'b0;
    check({tag, "_occ"}, 32'(exception_occurred), 32'd1);
    check({tag, "_ret"}, 32'(exception_returned), 32'd0);
    check({tag, "_mepc"}, new_mepc, pc);
    check({tag, "_mcause"}, new_mcause, {28'b0, cause});
    check({tag, "_mtval"}, new_mtval, tval);
    check({tag, "_rv_early"}, 32'(redirect_valid), 32'd0);
    step();
    check({tag, "_occ_once"}, 32'(exception_occurred), 32'd0);
    check({tag, "_mcause_held"}, new_mcause, {28'b0, cause});
    do_redirect(tag, exp_target(csr_mtvec, 1'b0, 0), hold);
  endtask

  // Interrupt: enter drain, wait d cycles, drain with optional stall in COMMIT.
  task automatic run_int(input string tag, input logic [31:0] ipc, input int d, input int sd,
                         input int hold);
    int code;
    int n;
    code = exp_code(csr_mie, csr_mip);
    int_pc = ipc;
    step();
    check({tag, "_hold"}, 32'(pipe_hold), 32'd1);
    check({tag, "_busy"}, 32'(trap_busy), 32'd1);
    for (int i = 0; i < d; i++) begin
      step();
      check({tag, "_hold_drain"}, 32'(pipe_hold), 32'd1);
      check({tag, "_occ_drain"}, 32'(exception_occurred), 32'd0);
    end
    pipe_drained = 1'b1;
    stall_n = (sd == 0);
    step();
    pipe_drained = 1'b0;
    csr_mip = 32'h0;
    if (sd == 0) begin
      check({tag, "_occ"}, 32'(exception_occurred), 32'd1);
    end else begin
      for (int i = 0; i < sd; i++) begin
        check({tag, "_occ_stalled"}, 32'(exception_occurred), 32'd0);
        check({tag, "_hold_stalled"}, 32'(pipe_hold), 32'd1);
        step();
      end
      stall_n = 1'b1;
      n = 0;
      while (!exception_occurred && n < 3) begin
        step();
        n++;
      end
      check({tag, "_occ_after_stall"}, 32'(exception_occurred), 32'd1);
    end
    check({tag, "_mcause"}, new_mcause, 32'h8000_0000 | 32'(code));
    check({tag, "_mepc"}, new_mepc, ipc);
    check({tag, "_mtval"}, new_mtval, 32'h0);
    check({tag, "_hold_commit"}, 32'(pipe_hold), 32'd1);
    step();
    check({tag, "_occ_once"}, 32'(exception_occurred), 32'd0);
    check({tag, "_hold_redir"}, 32'(pipe_hold), 32'd1);
    do_redirect(tag, exp_target(csr_mtvec, 1'b1, code), hold);
  endtask

  initial begin
    logic [31:0] r;
    int n;

    rst = 1'b1; stall_n = 1'b1; exc_req = 1'b0; exc_cause = 4'd0; exc_pc = 32'h0;
    exc_tval = 32'h0; mret_req = 1'b0; pipe_drained = 1'b0; int_pc = 32'h0;
    csr_mstatus = 32'h0; csr_mie = 32'h0; csr_mip = 32'h0; csr_mtvec = 32'h0;
    csr_mepc = 32'h0; redirect_ready = 1'b0;

    // Reset state
    step(); step();
    check("rst_occ", 32'(exception_occurred), 32'd0);
    check("rst_ret", 32'(exception_returned), 32'd0);
    check("rst_rv", 32'(redirect_valid), 32'd0);
    check("rst_rpc", redirect_pc, 32'h0);
    check("rst_hold", 32'(pipe_hold), 32'd0);
    check("rst_busy", 32'(trap_busy), 32'd0);
    check("rst_mcause", new_mcause, 32'h0);
    check("rst_mepc", new_mepc, 32'h0);
    rst = 1'b0;
    step();

    // Directed ecall
    csr_mtvec = 32'h200;
    csr_mstatus = 32'h8;
    run_exc("ecall", 4'd11, 32'h100, 32'h0, 0, 2);

    // Randomized exceptions with stall before acceptance, random mtvec mode
    for (int i = 0; i < 6; i++) begin
      r = $urandom;
      csr_mtvec = (r & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
      run_exc("exc_rand", 4'($urandom_range(0, 15)), $urandom, $urandom,
              $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // Directed MRET
    csr_mepc = 32'h44;
    r = new_mcause;
    mret_req = 1'b1;
    step();
    mret_req = 1'b0;
    check("mret_ret", 32'(exception_returned), 32'd1);
    check("mret_occ", 32'(exception_occurred), 32'd0);
    check("mret_mcause_held", new_mcause, r);
    step();
    check("mret_ret_once", 32'(exception_returned), 32'd0);
    do_redirect("mret", 32'h44, 1);

    // Randomized MRET
    for (int i = 0; i < 3; i++) begin
      csr_mepc = $urandom;
      mret_req = 1'b1;
      step();
      mret_req = 1'b0;
      check("mret_r_ret", 32'(exception_returned), 32'd1);
      step();
      check("mret_r_ret_once", 32'(exception_returned), 32'd0);
      do_redirect("mret_r", csr_mepc, $urandom_range(0, 2));
    end

    // Exception and MRET together: exception wins
    csr_mtvec = 32'h300; csr_mepc = 32'h5000;
    mret_req = 1'b1;
    run_exc("exc_mret", 4'd3, 32'h80, 32'h1234, 0, 0);
    check("exc_mret_noret", 32'(exception_returned), 32'd0);

    // Directed MTI with mtvec mode 01
    csr_mstatus = 32'h8; csr_mie = 32'h80; csr_mip = 32'h80; csr_mtvec = 32'h201;
    run_int("mti", 32'h40, 2, 0, 1);

    // Priority: all three pending
    csr_mie = 32'h888; csr_mip = 32'h888;
    run_int("prio", 32'h1000, 1, 0, 0);

    // Randomized interrupts: random enable/pending sets, drain delay, commit stall
    for (int i = 0; i < 6; i++) begin
      r = $urandom & 32'h888;
      if (r == 32'h0) r = 32'h80;
      csr_mstatus = 32'h8 | ($urandom & 32'hFFFF_FF77);
      csr_mie = r | ($urandom & 32'hFFFF_F777) | ($urandom & 32'h888);
      csr_mip = r | ($urandom & 32'hFFFF_F777);
      r = $urandom;
      csr_mtvec = (r & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1));
      run_int("int_rand", $urandom, $urandom_range(0, 4), $urandom_range(0, 2),
              $urandom_range(0, 2));
    end

    // Exception preempts an interrupt drain
    csr_mstatus = 32'h8; csr_mie = 32'h80; csr_mip = 32'h80; csr_mtvec = 32'h201;
    step();
    check("pre_hold", 32'(pipe_hold), 32'd1);
    step();
    exc_req = 1'b1; exc_cause = 4'd2; exc_pc = 32'h600; exc_tval = 32'hDEAD_BEEF;
    step();
    exc_req = 1'b0;
    csr_mip = 32'h0;
    check("pre_occ", 32'(exception_occurred), 32'd1);
    check("pre_mcause", new_mcause, 32'h2);
    check("pre_mepc", new_mepc, 32'h600);
    check("pre_mtval", new_mtval, 32'hDEAD_BEEF);
    check("pre_hold_commit", 32'(pipe_hold), 32'd1);
    step();
    check("pre_occ_once", 32'(exception_occurred), 32'd0);
    do_redirect("pre", 32'h200, 1);
    step();
    check("pre_no_int", 32'(exception_occurred), 32'd0);

    // Interrupt withdrawn during drain: no trap
    csr_mip = 32'h8; csr_mie = 32'h8;
    step();
    check("drop_hold", 32'(pipe_hold), 32'd1);
    step();
    csr_mstatus = 32'h0;
    step();
    check("drop_hold_off", 32'(pipe_hold), 32'd0);
    check("drop_busy", 32'(trap_busy), 32'd0);
    check("drop_occ", 32'(exception_occurred), 32'd0);
    csr_mip = 32'h0;

    // Drain timeout: hold lasts DRAIN_MAX cycles, no strobe
    csr_mstatus = 32'h8; csr_mie = 32'h80; csr_mip = 32'h80;
    step();
    n = 0;
    while (pipe_hold && n < 40) begin
      check("tmo_occ", 32'(exception_occurred), 32'd0);
      n++;
      step();
    end
    check("tmo_len", 32'(n), 32'(DRAIN_MAX));
    check("tmo_busy", 32'(trap_busy), 32'd0);
    csr_mip = 32'h0;
    step();
    check("tmo_idle_hold", 32'(pipe_hold), 32'd0);

    // Asynchronous reset while in REDIRECT
    csr_mtvec = 32'h700;
    exc_req = 1'b1; exc_cause = 4'd11; exc_pc = 32'h900; exc_tval = 32'h0;
    step();
    exc_req = 1'b0;
    step();
    check("arst_pre_rv", 32'(redirect_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_rv", 32'(redirect_valid), 32'd0);
    check("arst_rpc", redirect_pc, 32'h0);
    check("arst_busy", 32'(trap_busy), 32'd0);
    check("arst_mcause", new_mcause, 32'h0);
    check("arst_mepc", new_mepc, 32'h0);
    rst = 1'b0;
    step();
    check("arst_idle", 32'(trap_busy), 32'd0);
    check("arst_occ", 32'(exception_occurred), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
